line_tx_packer: RTL and testbench

- Downstream consumer of the ping-pong line buffer; runs in the read-side clock domain.
- Per line: clears the buffer read pointer, then pulls `PIX_IN_ROW` pixels one at a time with a read-enable strobe.
- Frames each line with a 4-byte header and serialises every 14-bit pixel into two bytes on a valid/ready byte stream toward the host interface (USB FIFO bridge).

---
 rtl/line_tx_packer_if.sv | 33 +++
 rtl/line_tx_packer.sv | 234 +++++++++++++++++++++++
 tb/tb_line_tx_packer.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_tx_packer_if.sv
// -----------------------------------------------------------------------------
// line_tx_packer_if
//
// Byte-stream handshake between the line packer and the host-side bridge
// (USB FIFO). A byte moves on a rising clock edge where TX_VALID and TX_READY
// are both high.
//
// Signals:
//   TX_DATA  [7:0]  byte on offer, held stable until accepted
//   TX_VALID        TX_DATA is valid
//   TX_READY        sink accepts the byte this cycle
//
// Modports:
//   master  - packer side (drives TX_DATA / TX_VALID)
//   slave   - sink side   (drives TX_READY)
// -----------------------------------------------------------------------------
interface line_tx_packer_if;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_READY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY
  );
endinterface

// File: rtl/line_tx_packer.sv
// -----------------------------------------------------------------------------
// line_tx_packer
//
// Read-side consumer of the ping-pong line buffer. For every LINE_READY it
// rewinds the buffer read pointer, emits a 4-byte line header
// (AA 55 line_lo line_hi), then reads PIX_IN_ROW pixels one at a time and
// sends each as two bytes (high part first) on the valid/ready byte stream.
//
// Parameters:
//   ADC_WIDHT   pixel width in bits (high byte carries bits above bit 7)
//   PIX_IN_ROW  pixels per line (1..1023)
//   LINE_W      width of the line counter
//
// Ports:
//   CLK          read-side clock, all logic on rising edge
//   RESET_N      asynchronous active-low reset
//   LINE_READY   pulse: a full line is available in the buffer
//   FRAME_START  pulse: the next line to start is line 0
//   BUF_RST      pulse: clears the buffer read pointer
//   BUF_RD_EN    pulse: one read strobe per pixel
//   PIX_DATA     buffer output, valid the cycle after BUF_RD_EN
//   tx           byte stream (master modport)
//   BUSY         high whenever a line is in progress
//   LINE_DONE    pulse: the last byte of a line was accepted
//   OVERRUN      sticky: LINE_READY arrived while BUSY
//   OVERRUN_CLR  synchronous clear of OVERRUN (a same-cycle set wins)
// -----------------------------------------------------------------------------
module line_tx_packer #(
  parameter int ADC_WIDHT  = 14,
  parameter int PIX_IN_ROW = 384,
  parameter int LINE_W     = 10
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 LINE_READY,
  input  logic                 FRAME_START,
  output logic                 BUF_RST,
  output logic                 BUF_RD_EN,
  input  logic [ADC_WIDHT-1:0] PIX_DATA,
  line_tx_packer_if.master     tx,
  output logic                 BUSY,
  output logic                 LINE_DONE,
  output logic                 OVERRUN,
  input  logic                 OVERRUN_CLR
);

  localparam int PIX_CNT_W = (PIX_IN_ROW > 1) ? $clog2(PIX_IN_ROW) : 1;
  localparam logic [PIX_CNT_W-1:0] LAST_PIX = PIX_CNT_W'(PIX_IN_ROW - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    RD,
    CAP,
    HI,
    LO
  } state_t;

  state_t                 state;
  state_t                 nxt_state;

  logic [1:0]             hdr_idx;
  logic [PIX_CNT_W-1:0]   pix_cnt;
  logic [LINE_W-1:0]      line_num;
  logic                   frame_pend;
  logic [ADC_WIDHT-1:0]   pix_reg;
  logic                   buf_rst_q;
  logic                   line_done_q;
  logic                   overrun_q;

  logic                   start_line;
  logic                   rd_en;
  logic                   tx_valid;
  logic [7:0]             tx_data;
  logic                   tx_fire;
  logic                   last_pix;

  // Header byte for position idx; the high line byte keeps only bits [9:8].
  function automatic logic [7:0] hdr_byte(input logic [1:0]        idx,
                                          input logic [LINE_W-1:0] ln);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'hAA;
      2'd1:    b = 8'h55;
      2'd2:    b = 8'(ln);
      default: b = 8'(ln >> 8) & 8'h03;
    endcase
    return b;
  endfunction

  // Pixel bits above bit 7, zero-extended into one byte.
  function automatic logic [7:0] pix_hi(input logic [ADC_WIDHT-1:0] p);
    return 8'(p >> 8);
  endfunction

  function automatic logic [7:0] pix_lo(input logic [ADC_WIDHT-1:0] p);
    return 8'(p);
  endfunction

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and stream outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt_state  = state;
    start_line = 1'b0;
    rd_en      = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    last_pix   = (pix_cnt == LAST_PIX);

    case (state)
      IDLE: begin
        if (LINE_READY) begin
          start_line = 1'b1;
          nxt_state  = HDR;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte(hdr_idx, line_num);
        if (tx.TX_READY && (hdr_idx == 2'd3)) begin
          nxt_state = RD;
        end
      end
      RD: begin
        rd_en     = 1'b1;
        nxt_state = CAP;
      end
      CAP: begin
        // Buffer output is valid one cycle after the strobe.
        nxt_state = HI;
      end
      HI: begin
        tx_valid = 1'b1;
        tx_data  = pix_hi(pix_reg);
        if (tx.TX_READY) begin
          nxt_state = LO;
        end
      end
      LO: begin
        tx_valid = 1'b1;
        tx_data  = pix_lo(pix_reg);
        if (tx.TX_READY) begin
          nxt_state = last_pix ? IDLE : RD;
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    tx_fire = tx_valid && tx.TX_READY;
  end

  // ---------------------------------------------------------------------------
  // Control registers: counters, framing, pulses, sticky overrun
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hdr_idx     <= 2'd0;
      pix_cnt     <= '0;
      line_num    <= '0;
      frame_pend  <= 1'b0;
      buf_rst_q   <= 1'b0;
      line_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      buf_rst_q   <= start_line;
      line_done_q <= (state == LO) && tx_fire && last_pix;

      if (start_line) begin
        hdr_idx <= 2'd0;
      end else if ((state == HDR) && tx_fire) begin
        hdr_idx <= hdr_idx + 2'd1;
      end

      if (start_line) begin
        pix_cnt <= '0;
      end else if ((state == LO) && tx_fire && !last_pix) begin
        pix_cnt <= pix_cnt + PIX_CNT_W'(1);
      end

      // A pending or coincident frame start makes the starting line line 0;
      // a frame start during a line only affects the next one.
      if (start_line && (frame_pend || FRAME_START)) begin
        line_num <= '0;
      end else if ((state == LO) && tx_fire && last_pix) begin
        line_num <= line_num + LINE_W'(1);
      end

      if (start_line) begin
        frame_pend <= 1'b0;
      end else if (FRAME_START) begin
        frame_pend <= 1'b1;
      end

      // Set has priority over clear.
      if (LINE_READY && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (OVERRUN_CLR) begin
        overrun_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel capture (data only, no reset needed: not visible outside HI/LO)
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (state == CAP) begin
      pix_reg <= PIX_DATA;
    end
  end

  assign tx.TX_VALID = tx_valid;
  assign tx.TX_DATA  = tx_data;
  assign BUF_RST     = buf_rst_q;
  assign BUF_RD_EN   = rd_en;
  assign BUSY        = (state != IDLE);
  assign LINE_DONE   = line_done_q;
  assign OVERRUN     = overrun_q;

endmodule

// File: tb/tb_line_tx_packer.sv
module tb_line_tx_packer;

  localparam int PIX  = 4;
  localparam int MASK = 32767;

  logic        CLK         = 1'b0;
  logic        RESET_N     = 1'b1;
  logic        LINE_READY  = 1'b0;
  logic        FRAME_START = 1'b0;
  logic        OVERRUN_CLR = 1'b0;
  logic        BUF_RST;
  logic        BUF_RD_EN;
  logic        BUSY;
  logic        LINE_DONE;
  logic        OVERRUN;
  logic [13:0] PIX_DATA = 14'h0;

  line_tx_packer_if tx_if ();

  line_tx_packer #(
    .ADC_WIDHT  (14),
    .PIX_IN_ROW (PIX),
    .LINE_W     (10)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .LINE_READY  (LINE_READY),
    .FRAME_START (FRAME_START),
    .BUF_RST     (BUF_RST),
    .BUF_RD_EN   (BUF_RD_EN),
    .PIX_DATA    (PIX_DATA),
    .tx          (tx_if),
    .BUSY        (BUSY),
    .LINE_DONE   (LINE_DONE),
    .OVERRUN     (OVERRUN),
    .OVERRUN_CLR (OVERRUN_CLR)
  );

  always #5 CLK = ~CLK;

  // Line buffer contents returned for every line.
  function automatic logic [13:0] pix_word(input int idx);
    case (idx)
      0:       return 14'h3ABC;
      1:       return 14'h0001;
      2:       return 14'h2000;
      default: return 14'h3FFF;
    endcase
  endfunction

  // Buffer read port: pointer rewound by BUF_RST, data one cycle after strobe.
  int rd_ptr = 0;
  always @(posedge CLK) begin
    if (BUF_RST) begin
      rd_ptr <= 0;
    end else if (BUF_RD_EN) begin
      PIX_DATA <= pix_word(rd_ptr);
      rd_ptr   <= rd_ptr + 1;
    end
  end

  // Hand-computed byte stream of one line; bytes 2/3 carry the line number.
  function automatic logic [7:0] ref_byte(input int i, input int ln);
    case (i)
      0:  return 8'hAA;
      1:  return 8'h55;
      2:  return 8'(ln & 255);
      3:  return 8'((ln >> 8) & 3);
      4:  return 8'h3A;
      5:  return 8'hBC;
      6:  return 8'h00;
      7:  return 8'h01;
      8:  return 8'h20;
      9:  return 8'h00;
      10: return 8'h3F;
      default: return 8'hFF;
    endcase
  endfunction

  // Monitor, sampled on the falling edge.
  logic [7:0] rx_mem [0:MASK];
  int         n_rx = 0, n_rst = 0, n_rd = 0, n_done = 0, n_sv = 0, done_rx = 0;
  logic       done_busy  = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge CLK) begin
    if (RESET_N) begin
      if (tx_if.TX_VALID && tx_if.TX_READY) begin
        rx_mem[n_rx & MASK] <= tx_if.TX_DATA;
        n_rx <= n_rx + 1;
      end
      if (BUF_RST)   n_rst <= n_rst + 1;
      if (BUF_RD_EN) n_rd  <= n_rd + 1;
      if (LINE_DONE) begin
        n_done    <= n_done + 1;
        done_rx   <= n_rx;
        done_busy <= BUSY;
      end
      if (prev_stall && (!tx_if.TX_VALID || (tx_if.TX_DATA !== prev_data)))
        n_sv <= n_sv + 1;
      prev_stall <= tx_if.TX_VALID && !tx_if.TX_READY;
      prev_data  <= tx_if.TX_DATA;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  int tests = 0;
  int fails = 0;
  int b_rx, b_rst, b_rd, b_done, b_sv;
  bit tmo;

  function automatic logic [7:0] rxb(input int i);
    return rx_mem[(b_rx + i) & MASK];
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    LINE_READY  = 1'b0;
    FRAME_START = 1'b0;
    OVERRUN_CLR = 1'b0;
    tx_if.TX_READY = 1'b1;
    RESET_N = 1'b0;
    repeat (3) tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic start_line(input bit fs);
    b_rx   = n_rx;
    b_rst  = n_rst;
    b_rd   = n_rd;
    b_done = n_done;
    b_sv   = n_sv;
    LINE_READY  = 1'b1;
    FRAME_START = fs;
    tick();
    LINE_READY  = 1'b0;
    FRAME_START = 1'b0;
  endtask

  // Waits for LINE_DONE; with bp set, TX_READY toggles and is held low
  // for 5 cycles while the third byte is on offer.
  task automatic wait_done(input int budget, input bit bp, output bit timed_out);
    int  hold = 0;
    bit  held = 0;
    for (int c = 0; c < budget; c++) begin
      if (n_done != b_done) break;
      if (bp) begin
        if (!held && ((n_rx - b_rx) == 2)) begin
          hold = 5;
          held = 1;
        end
        if (hold > 0) begin
          tx_if.TX_READY = 1'b0;
          hold--;
        end else begin
          tx_if.TX_READY = c[0];
        end
      end else begin
        tx_if.TX_READY = 1'b1;
      end
      tick();
    end
    tx_if.TX_READY = 1'b1;
    timed_out = (n_done == b_done);
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    tx_if.TX_READY = 1'b1;
    #1;
    tests++;
    if ({tx_if.TX_VALID, tx_if.TX_DATA, BUF_RST, BUF_RD_EN, BUSY, LINE_DONE, OVERRUN} !== 14'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %04h required 0000",
               {tx_if.TX_VALID, tx_if.TX_DATA, BUF_RST, BUF_RD_EN, BUSY, LINE_DONE, OVERRUN});
    end
    apply_reset();
    tests++;
    if ({BUSY, tx_if.TX_VALID, BUF_RD_EN} !== 3'b000) begin
      fails++;
      $display("FAIL reset_idle: got %03b required 000", {BUSY, tx_if.TX_VALID, BUF_RD_EN});
    end
  endtask

  task automatic test_first_line();
    start_line(1'b0);
    tests++;
    if (BUSY !== 1'b1 || BUF_RST !== 1'b1) begin
      fails++;
      $display("FAIL first_busy_bufrst: got %b%b required 11", BUSY, BUF_RST);
    end
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo) begin fails++; $display("FAIL first_timeout: got no LINE_DONE required LINE_DONE"); end
    tests++;
    if ((n_rx - b_rx) !== 12) begin
      fails++; $display("FAIL first_bytecount: got %0d required 12", n_rx - b_rx);
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (rxb(i) !== ref_byte(i, 0)) begin
        fails++;
        $display("FAIL first_byte%0d: got %02h required %02h", i, rxb(i), ref_byte(i, 0));
      end
    end
    tests++;
    if ({n_rst - b_rst, n_rd - b_rd, n_done - b_done} !== {32'd1, 32'd4, 32'd1}) begin
      fails++;
      $display("FAIL first_pulses: got rst=%0d rd=%0d done=%0d required 1 4 1",
               n_rst - b_rst, n_rd - b_rd, n_done - b_done);
    end
    tests++;
    if ((done_rx - b_rx) !== 12 || done_busy !== 1'b0) begin
      fails++;
      $display("FAIL first_done_timing: got bytes=%0d busy=%b required 12 0", done_rx - b_rx, done_busy);
    end
  endtask

  task automatic test_backpressure();
    // line_num is 1 after the first line
    start_line(1'b0);
    wait_done(400, 1'b1, tmo);
    tests++;
    if (tmo) begin fails++; $display("FAIL bp_timeout: got no LINE_DONE required LINE_DONE"); end
    tests++;
    if ((n_rx - b_rx) !== 12) begin
      fails++; $display("FAIL bp_bytecount: got %0d required 12", n_rx - b_rx);
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (rxb(i) !== ref_byte(i, 1)) begin
        fails++;
        $display("FAIL bp_byte%0d: got %02h required %02h", i, rxb(i), ref_byte(i, 1));
      end
    end
    tests++;
    if ((n_sv - b_sv) !== 0) begin
      fails++; $display("FAIL bp_stall_stable: got %0d violations required 0", n_sv - b_sv);
    end
    tests++;
    if ((n_rd - b_rd) !== 4) begin
      fails++; $display("FAIL bp_rd_count: got %0d required 4", n_rd - b_rd);
    end
  endtask

  task automatic test_line_numbering();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      start_line(1'b0);
      wait_done(200, 1'b0, tmo);
      tests++;
      if (tmo || rxb(2) !== 8'(k) || rxb(3) !== 8'h00) begin
        fails++;
        $display("FAIL num_line%0d: got tmo=%0d hdr=%02h %02h required 0 %02h 00", k, tmo, rxb(2), rxb(3), 8'(k));
      end
    end
    start_line(1'b0);
    repeat (6) tick();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || rxb(2) !== 8'h03 || rxb(3) !== 8'h00) begin
      fails++;
      $display("FAIL num_midframe: got tmo=%0d hdr=%02h %02h required 0 03 00", tmo, rxb(2), rxb(3));
    end
    start_line(1'b0);
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || rxb(2) !== 8'h00 || rxb(3) !== 8'h00) begin
      fails++;
      $display("FAIL num_after_frame: got tmo=%0d hdr=%02h %02h required 0 00 00", tmo, rxb(2), rxb(3));
    end
  endtask

  task automatic test_wrap();
    int nt = 0;
    apply_reset();
    for (int l = 0; l < 1023; l++) begin
      start_line(1'b0);
      wait_done(200, 1'b0, tmo);
      if (tmo) nt++;
    end
    tests++;
    if (nt !== 0) begin fails++; $display("FAIL wrap_timeouts: got %0d required 0", nt); end
    start_line(1'b0);
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || rxb(2) !== 8'hFF || rxb(3) !== 8'h03) begin
      fails++;
      $display("FAIL wrap_1023: got tmo=%0d hdr=%02h %02h required 0 FF 03", tmo, rxb(2), rxb(3));
    end
    start_line(1'b0);
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || rxb(2) !== 8'h00 || rxb(3) !== 8'h00) begin
      fails++;
      $display("FAIL wrap_0: got tmo=%0d hdr=%02h %02h required 0 00 00", tmo, rxb(2), rxb(3));
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    start_line(1'b0);
    LINE_READY = 1'b1;          // lands in HDR
    tick();
    LINE_READY = 1'b0;
    tests++;
    if (OVERRUN !== 1'b1) begin fails++; $display("FAIL ovr_hdr: got %b required 1", OVERRUN); end
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    tests++;
    if (OVERRUN !== 1'b0) begin fails++; $display("FAIL ovr_clr_busy: got %b required 0", OVERRUN); end
    for (int c = 0; c < 50; c++) begin
      if ((n_rx - b_rx) >= 5) break;
      tick();
    end
    tests++;
    if ((n_rx - b_rx) !== 5) begin fails++; $display("FAIL ovr_reach_lo: got %0d bytes required 5", n_rx - b_rx); end
    LINE_READY = 1'b1;          // lands in LO of pixel 0
    tick();
    LINE_READY = 1'b0;
    tests++;
    if (OVERRUN !== 1'b1) begin fails++; $display("FAIL ovr_lo: got %b required 1", OVERRUN); end
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || (n_rx - b_rx) !== 12 || (n_rd - b_rd) !== 4 || (n_rst - b_rst) !== 1) begin
      fails++;
      $display("FAIL ovr_line_counts: got tmo=%0d bytes=%0d rd=%0d rst=%0d required 0 12 4 1",
               tmo, n_rx - b_rx, n_rd - b_rd, n_rst - b_rst);
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (rxb(i) !== ref_byte(i, 0)) begin
        fails++;
        $display("FAIL ovr_byte%0d: got %02h required %02h", i, rxb(i), ref_byte(i, 0));
      end
    end
    tick();
    tests++;
    if (BUSY !== 1'b0 || OVERRUN !== 1'b1) begin
      fails++; $display("FAIL ovr_sticky_idle: got busy=%b ovr=%b required 0 1", BUSY, OVERRUN);
    end
    OVERRUN_CLR = 1'b1;
    tick();
    OVERRUN_CLR = 1'b0;
    tests++;
    if (OVERRUN !== 1'b0) begin fails++; $display("FAIL ovr_clr_idle: got %b required 0", OVERRUN); end
    start_line(1'b0);
    LINE_READY  = 1'b1;
    OVERRUN_CLR = 1'b1;
    tick();
    LINE_READY  = 1'b0;
    OVERRUN_CLR = 1'b0;
    tests++;
    if (OVERRUN !== 1'b1) begin fails++; $display("FAIL ovr_set_wins: got %b required 1", OVERRUN); end
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || rxb(2) !== 8'h01 || (n_rx - b_rx) !== 12) begin
      fails++;
      $display("FAIL ovr_next_line: got tmo=%0d hdr=%02h bytes=%0d required 0 01 12", tmo, rxb(2), n_rx - b_rx);
    end
  endtask

  task automatic test_reset_midline();
    apply_reset();
    start_line(1'b0);
    wait_done(200, 1'b0, tmo);
    start_line(1'b0);           // line 1, abandoned mid-way
    for (int c = 0; c < 60; c++) begin
      if (((n_rx - b_rx) >= 8) && tx_if.TX_VALID) break;
      tick();
    end
    tests++;
    if (tx_if.TX_VALID !== 1'b1 || tx_if.TX_DATA !== 8'h20 || BUSY !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_in_hi: got valid=%b data=%02h busy=%b required 1 20 1",
               tx_if.TX_VALID, tx_if.TX_DATA, BUSY);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    tests++;
    if ({tx_if.TX_VALID, tx_if.TX_DATA, BUF_RST, BUF_RD_EN, BUSY, LINE_DONE, OVERRUN} !== 14'h0) begin
      fails++;
      $display("FAIL rst_mid_outputs: got %04h required 0000",
               {tx_if.TX_VALID, tx_if.TX_DATA, BUF_RST, BUF_RD_EN, BUSY, LINE_DONE, OVERRUN});
    end
    repeat (2) tick();
    RESET_N = 1'b1;
    tick();
    start_line(1'b0);
    wait_done(200, 1'b0, tmo);
    tests++;
    if (tmo || (n_rx - b_rx) !== 12 || (n_rd - b_rd) !== 4) begin
      fails++;
      $display("FAIL rst_mid_next_counts: got tmo=%0d bytes=%0d rd=%0d required 0 12 4",
               tmo, n_rx - b_rx, n_rd - b_rd);
    end
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (rxb(i) !== ref_byte(i, 0)) begin
        fails++;
        $display("FAIL rst_mid_byte%0d: got %02h required %02h", i, rxb(i), ref_byte(i, 0));
      end
    end
  endtask

  initial begin
    tx_if.TX_READY = 1'b1;
    #2;
    test_reset();
    test_first_line();
    test_backpressure();
    test_line_numbering();
    test_wrap();
    test_overrun();
    test_reset_midline();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
